prince_ti_core: RTL and testbench
=================================

PRINCE_TI_CORE -- requirements
Module: prince_ti_core

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  begin encryption; sampled only in IDLE.
REQ-004 SHALL have ports: pt_v, pt_w, pt_x, pt_y, pt_z  in  64 each  plaintext shares; XOR of the five equals the plaintext.
REQ-005 SHALL have ports: k0, k1  in  64 each  whitening key and core key; held stable while busy.
REQ-006 SHALL have ports: ct_v, ct_w, ct_x, ct_y, ct_z  out  64 each  ciphertext shares, registered.
REQ-007 SHALL have ports: busy  out  1  high in RUN.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse when ct_* become valid.
REQ-009 SHALL have one clock and an asynchronous active-low reset; no other clocks or resets.

Function
REQ-010 SHALL implement FSM with states IDLE, RUN and DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-011 SHALL, in IDLE with start=1, load state registers at the next edge: v = pt_v ^ k0 ^ k1 ^ RC0; w..z = pt_w..pt_z unchanged. It SHALL enter RUN with rnd=1.
REQ-012 SHALL, in RUN, feed state shares to one combinational round instance with rc = RC[rnd] ^ k1.
REQ-013 SHALL drive inv=1 for rnd 1..6 (forward rounds plus middle S-layer and M'), and inv=0 for rnd 7..11 (inverse rounds).
REQ-014 SHALL, at each RUN edge with rnd<11, register ov..oz into the state and increment rnd (4-bit counter).
REQ-015 SHALL, at the RUN edge with rnd=11, capture outputs as follows and enter DONE: ct_v = o_half_v ^ k0p, where k0p = {k0[0], k0[63:1]} ^ {63'b0, k0[63]}; ct_w..ct_z = o_half_w..o_half_z.
REQ-016 SHALL assert done during DONE only; the start-edge-to-done-high latency SHALL be exactly 12 cycles.
REQ-017 SHALL hold ct_* unchanged from DONE until the next completion; a new start SHALL NOT clear ct_*.
REQ-018 SHALL ignore start while in RUN or DONE; no queuing.
REQ-019 SHALL never combine shares; only the v share receives key, constant and whitening.
REQ-020 SHALL accept start in the cycle immediately after DONE, giving back-to-back operations with a 13-cycle period.

Reset
REQ-021 SHALL, on rst_n=0, asynchronously force IDLE, rnd=0, all state registers to 0, ct_* to 0, busy=0 and done=0.
REQ-022 SHALL, on reset asserted mid-RUN, abort the operation with no done pulse; after release it SHALL behave as after power-up.

Structure
REQ-023 SHALL take the RC0..RC11 constants (64-bit), the FSM state encoding and the round-count constant (11) from shared package prince_ti_pkg.
REQ-024 SHALL instantiate exactly one sub-module, prince_round; all other logic is local.

Verification
REQ-025 SHALL cover: pt=0, k0=0, k1=0, random masks on w..z with v = XOR of the masks -> done at start+12; XOR(ct_*) = 818665aa0d02dfda.
REQ-026 SHALL cover: pt=ffffffffffffffff, k0=0, k1=0, fresh random masks -> XOR(ct_*) = 604ae6ca03c20ada.
REQ-027 SHALL cover: pt=0, k0=ffffffffffffffff, k1=0 -> 9fb51935fc3df524; and pt=0123456789abcdef, k0=0, k1=fedcba9876543210 -> ae25ad3ca8fa9ccf.
REQ-028 SHALL cover: start pulsed at rnd=5 of a running operation -> ignored; ct_* and done timing unchanged.
REQ-029 SHALL cover: rst_n low at rnd=7 -> outputs 0, no done; next start yields the correct vector.
REQ-030 SHALL cover: start held high continuously for 3 operations -> done every 13 cycles, each ct_* correct.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// Shared constants, types and share-wise helper functions for the masked PRINCE core.
package prince_ti_pkg;

   localparam int NSHARES = 5;
   localparam logic [3:0] LAST_ROUND = 4'd11;
   localparam logic [3:0] MID_ROUND  = 4'd6;

   typedef logic [63:0] word_t;
   typedef logic [NSHARES-1:0][63:0] shares_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam word_t RC0  = 64'h0000000000000000;
   localparam word_t RC1  = 64'h13198a2e03707344;
   localparam word_t RC2  = 64'ha4093822299f31d0;
   localparam word_t RC3  = 64'h082efa98ec4e6c89;
   localparam word_t RC4  = 64'h452821e638d01377;
   localparam word_t RC5  = 64'hbe5466cf34e90c6c;
   localparam word_t RC6  = 64'h7ef84f78fd955cb1;
   localparam word_t RC7  = 64'h85840851f1ac43aa;
   localparam word_t RC8  = 64'hc882d32f25323c54;
   localparam word_t RC9  = 64'h64a51195e0e3610d;
   localparam word_t RC10 = 64'hd3b5a399ca0c2399;
   localparam word_t RC11 = 64'hc0ac29b7c97c50dd;

   // Entry x of each S-box sits in bits [4x+3:4x].
   localparam word_t SBOX_TBL = 64'h4D5E087619CA23FB;
   localparam word_t SINV_TBL = 64'h1CE5046A98DF237B;

   function automatic word_t roundConst(input logic [3:0] r);
      case (r)
         4'd0:    return RC0;
         4'd1:    return RC1;
         4'd2:    return RC2;
         4'd3:    return RC3;
         4'd4:    return RC4;
         4'd5:    return RC5;
         4'd6:    return RC6;
         4'd7:    return RC7;
         4'd8:    return RC8;
         4'd9:    return RC9;
         4'd10:   return RC10;
         4'd11:   return RC11;
         default: return '0;
      endcase
   endfunction

   // Algebraic normal form of each S-box output bit, via the Moebius transform.
   function automatic logic [3:0][15:0] anfTable(input word_t tbl);
      logic [3:0][15:0] t;
      for (int ob = 0; ob < 4; ob++)
         for (int x = 0; x < 16; x++)
            t[ob][x] = tbl[4*x+ob];
      for (int ob = 0; ob < 4; ob++)
         for (int i = 0; i < 4; i++)
            for (int x = 0; x < 16; x++)
               if (x[i])
                  t[ob][x] = t[ob][x] ^ t[ob][x ^ (1 << i)];
      return t;
   endfunction

   localparam logic [3:0][15:0] SBOX_ANF = anfTable(SBOX_TBL);
   localparam logic [3:0][15:0] SINV_ANF = anfTable(SINV_TBL);

   // Every cross-share product lands in the lowest output share it does not read,
   // so no output share ever sees all input shares of a nibble.
   function automatic shares_t sboxLayer(input shares_t x, input logic [3:0][15:0] anf);
      shares_t y;
      logic prod;
      logic [NSHARES-1:0] used;
      int dst;
      y = '0;
      for (int nib = 0; nib < 16; nib++)
         for (int ob = 0; ob < 4; ob++)
            for (int m = 0; m < 16; m++)
               if (anf[ob][m]) begin
                  if (m == 0) begin
                     y[0][4*nib+ob] = ~y[0][4*nib+ob];
                  end else begin
                     for (int s0 = 0; s0 < (m[0] ? NSHARES : 1); s0++)
                        for (int s1 = 0; s1 < (m[1] ? NSHARES : 1); s1++)
                           for (int s2 = 0; s2 < (m[2] ? NSHARES : 1); s2++)
                              for (int s3 = 0; s3 < (m[3] ? NSHARES : 1); s3++) begin
                                 prod = 1'b1;
                                 used = '0;
                                 if (m[0]) begin prod = prod & x[s0][4*nib];   used[s0] = 1'b1; end
                                 if (m[1]) begin prod = prod & x[s1][4*nib+1]; used[s1] = 1'b1; end
                                 if (m[2]) begin prod = prod & x[s2][4*nib+2]; used[s2] = 1'b1; end
                                 if (m[3]) begin prod = prod & x[s3][4*nib+3]; used[s3] = 1'b1; end
                                 dst = 0;
                                 for (int d = NSHARES-1; d >= 0; d--)
                                    if (!used[d])
                                       dst = d;
                                 y[dst][4*nib+ob] = y[dst][4*nib+ob] ^ prod;
                              end
                  end
               end
      return y;
   endfunction

   // Bits and nibbles are numbered from the MSB, as in the cipher description.
   function automatic word_t mPrime(input word_t x);
      word_t y;
      int hat;
      logic acc;
      y = '0;
      for (int q = 0; q < 4; q++) begin
         hat = (q == 1 || q == 2) ? 1 : 0;
         for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
               acc = 1'b0;
               for (int c = 0; c < 4; c++)
                  if (j != (r + c + hat) % 4)
                     acc = acc ^ x[63 - 16*q - 4*c - j];
               y[63 - 16*q - 4*r - j] = acc;
            end
      end
      return y;
   endfunction

   function automatic word_t shiftRows(input word_t x);
      word_t y;
      int src;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
         y[63 - 4*i -: 4] = x[63 - 4*src -: 4];
      end
      return y;
   endfunction

   function automatic word_t shiftRowsInv(input word_t x);
      word_t y;
      int src;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         src = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
         y[63 - 4*i -: 4] = x[63 - 4*src -: 4];
      end
      return y;
   endfunction

endpackage

// File: rtl/prince_round.sv
// One combinational masked PRINCE step: forward round, middle layer or inverse round,
// selected by inv_i/mid_i; the round constant only touches share 0.
module prince_round
   import prince_ti_pkg::*;
(
   input  shares_t state_i,
   input  word_t   rc_i,
   input  logic    inv_i,
   input  logic    mid_i,
   output shares_t out_o
);

   shares_t sboxOut;
   shares_t preMix;
   shares_t mixed;
   shares_t sinvOut;
   shares_t res;

   // Forward: S, M', SR. Middle: S, M', S^-1. Inverse: SR^-1, M', S^-1.
   always_comb begin
      sboxOut = sboxLayer(state_i, SBOX_ANF);
      preMix  = '0;
      mixed   = '0;
      for (int s = 0; s < NSHARES; s++) begin
         preMix[s] = inv_i ? sboxOut[s] : shiftRowsInv(state_i[s]);
         mixed[s]  = mPrime(preMix[s]);
      end
      sinvOut = sboxLayer(mixed, SINV_ANF);
      res     = '0;
      for (int s = 0; s < NSHARES; s++)
         res[s] = (inv_i && !mid_i) ? shiftRows(mixed[s]) : sinvOut[s];
      res[0] = res[0] ^ rc_i;
      out_o  = res;
   end

endmodule

// File: rtl/prince_ti_core.sv
// Five-share masked PRINCE encryption core: one round per cycle, start to done in twelve
// cycles, ciphertext shares held until the next completion.
module prince_ti_core
   import prince_ti_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] pt_v,
   input  logic [63:0] pt_w,
   input  logic [63:0] pt_x,
   input  logic [63:0] pt_y,
   input  logic [63:0] pt_z,
   input  logic [63:0] k0,
   input  logic [63:0] k1,
   output logic [63:0] ct_v,
   output logic [63:0] ct_w,
   output logic [63:0] ct_x,
   output logic [63:0] ct_y,
   output logic [63:0] ct_z,
   output logic        busy,
   output logic        done
);

   state_e     state_q;
   logic [3:0] rnd_q;
   shares_t    shares_q;
   shares_t    ct_q;
   logic       busy_q;
   logic       done_q;

   shares_t    load_d;
   shares_t    ct_d;
   shares_t    roundOut;
   word_t      rc;
   word_t      k0p;
   logic       inv;
   logic       mid;

   always_comb begin
      k0p    = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
      rc     = roundConst(rnd_q) ^ k1;
      inv    = (rnd_q <= MID_ROUND);
      mid    = (rnd_q == MID_ROUND);
      load_d = {pt_z, pt_y, pt_x, pt_w, pt_v ^ k0 ^ k1 ^ RC0};
      ct_d    = roundOut;
      ct_d[0] = roundOut[0] ^ k0p;
   end

   prince_round u_round (
      .state_i (shares_q),
      .rc_i    (rc),
      .inv_i   (inv),
      .mid_i   (mid),
      .out_o   (roundOut)
   );

   // ct_q is written only on completion, so a new start leaves the last result visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rnd_q    <= '0;
         shares_q <= '0;
         ct_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  shares_q <= load_d;
                  rnd_q    <= 4'd1;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (rnd_q == LAST_ROUND) begin
                  ct_q    <= ct_d;
                  rnd_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  shares_q <= roundOut;
                  rnd_q    <= rnd_q + 4'd1;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ct_v = ct_q[0];
   assign ct_w = ct_q[1];
   assign ct_x = ct_q[2];
   assign ct_y = ct_q[3];
   assign ct_z = ct_q[4];
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_prince_ti_core.sv
// Bench for prince_ti_core: known PRINCE vectors under random masks, with a queue of
// expected ciphertexts filled at start and drained on each done pulse.
module tb_prince_ti_core;

   localparam logic [63:0] CT_ZERO  = 64'h818665aa0d02dfda;
   localparam logic [63:0] CT_ONES  = 64'h604ae6ca03c20ada;
   localparam logic [63:0] CT_K0    = 64'h9fb51935fc3df524;
   localparam logic [63:0] CT_K1    = 64'h78a54cbe737bb7ef;
   localparam logic [63:0] CT_MIXED = 64'hae25ad3ca8fa9ccf;
   localparam logic [63:0] ONES     = 64'hffffffffffffffff;
   localparam logic [63:0] PT_MIXED = 64'h0123456789abcdef;
   localparam logic [63:0] K1_MIXED = 64'hfedcba9876543210;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] pt_v, pt_w, pt_x, pt_y, pt_z;
   logic [63:0] k0, k1;
   logic [63:0] ct_v, ct_w, ct_x, ct_y, ct_z;
   logic        busy;
   logic        done;

   int compared   = 0;
   int mismatched = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   prince_ti_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .pt_v  (pt_v),
      .pt_w  (pt_w),
      .pt_x  (pt_x),
      .pt_y  (pt_y),
      .pt_z  (pt_z),
      .k0    (k0),
      .k1    (k1),
      .ct_v  (ct_v),
      .ct_w  (ct_w),
      .ct_x  (ct_x),
      .ct_y  (ct_y),
      .ct_z  (ct_z),
      .busy  (busy),
      .done  (done)
   );

   function automatic logic [63:0] ctXor();
      return ct_v ^ ct_w ^ ct_x ^ ct_y ^ ct_z;
   endfunction

   // Fresh random masks on w..z; v carries the plaintext folded with the masks.
   task automatic applyStimulus(input logic [63:0] pt, input logic [63:0] key0,
                                input logic [63:0] key1, input logic [63:0] expCt);
      pt_w = {$urandom, $urandom};
      pt_x = {$urandom, $urandom};
      pt_y = {$urandom, $urandom};
      pt_z = {$urandom, $urandom};
      pt_v = pt ^ pt_w ^ pt_x ^ pt_y ^ pt_z;
      k0   = key0;
      k1   = key1;
      sb.push_back(expCt);
   endtask

   task automatic popExpected(output logic [63:0] e);
      if (sb.size() == 0) e = 'x;
      else e = sb.pop_front();
   endtask

   task automatic waitDone(input int budget, output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      pt_v = '0; pt_w = '0; pt_x = '0; pt_y = '0; pt_z = '0;
      k0 = '0; k1 = '0;
      repeat (2) @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      compared++;
      if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      compared++;
      if ({ct_v, ct_w, ct_x, ct_y, ct_z} !== 320'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ct: got v=%h w=%h expected all zero", ct_v, ct_w);
      end
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_zero_vector();
      int cyc; bit seen; logic [63:0] e;
      applyStimulus('0, '0, '0, CT_ZERO);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      compared++;
      if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL run_busy: got %b expected 1", busy); end
      waitDone(20, cyc, seen);
      compared++;
      if (!seen || cyc + 1 != 12) begin
         mismatched++;
         $display("[TB] FAIL zero_latency: got %0d (seen=%0b) expected 12", cyc + 1, seen);
      end
      popExpected(e);
      compared++;
      if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL zero_ct: got %h expected %h", ctXor(), e); end
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL done_pulse: got done=%b busy=%b expected 0/0", done, busy);
      end
   endtask

   task automatic test_ones_vector();
      int cyc; bit seen; logic [63:0] e;
      applyStimulus(ONES, '0, '0, CT_ONES);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(20, cyc, seen);
      compared++;
      if (!seen || cyc + 1 != 12) begin
         mismatched++;
         $display("[TB] FAIL ones_latency: got %0d (seen=%0b) expected 12", cyc + 1, seen);
      end
      popExpected(e);
      compared++;
      if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL ones_ct: got %h expected %h", ctXor(), e); end
      @(negedge clk);
   endtask

   task automatic test_key_vectors();
      int cyc; bit seen; logic [63:0] e;
      applyStimulus('0, ONES, '0, CT_K0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(20, cyc, seen);
      compared++;
      if (!seen) begin mismatched++; $display("[TB] FAIL k0_timeout: got no done expected done"); end
      popExpected(e);
      compared++;
      if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL k0_ct: got %h expected %h", ctXor(), e); end
      @(negedge clk);
      applyStimulus(PT_MIXED, '0, K1_MIXED, CT_MIXED);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      compared++;
      if (ctXor() !== CT_K0) begin mismatched++; $display("[TB] FAIL ct_hold: got %h expected %h", ctXor(), CT_K0); end
      waitDone(20, cyc, seen);
      compared++;
      if (!seen || cyc + 3 != 12) begin
         mismatched++;
         $display("[TB] FAIL mixed_latency: got %0d (seen=%0b) expected 12", cyc + 3, seen);
      end
      popExpected(e);
      compared++;
      if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL mixed_ct: got %h expected %h", ctXor(), e); end
      @(negedge clk);
      applyStimulus('0, '0, ONES, CT_K1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(20, cyc, seen);
      popExpected(e);
      compared++;
      if (!seen || ctXor() !== e) begin
         mismatched++;
         $display("[TB] FAIL k1_ct: got %h (seen=%0b) expected %h", ctXor(), seen, e);
      end
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int cyc; bit seen; int sawDone; logic [63:0] e;
      applyStimulus(PT_MIXED, '0, K1_MIXED, CT_MIXED);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      pt_v = ONES;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(20, cyc, seen);
      compared++;
      if (!seen || cyc + 6 != 12) begin
         mismatched++;
         $display("[TB] FAIL ignore_latency: got %0d (seen=%0b) expected 12", cyc + 6, seen);
      end
      popExpected(e);
      compared++;
      if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL ignore_ct: got %h expected %h", ctXor(), e); end
      sawDone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) sawDone++;
      end
      compared++;
      if (sawDone != 0) begin mismatched++; $display("[TB] FAIL no_queue: got %0d active cycles expected 0", sawDone); end
   endtask

   task automatic test_reset_mid_run();
      int cyc; bit seen; int sawDone; logic [63:0] e;
      applyStimulus('0, '0, '0, CT_ZERO);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_flags: got busy=%b done=%b expected 0/0", busy, done);
      end
      compared++;
      if ({ct_v, ct_w, ct_x, ct_y, ct_z} !== 320'b0) begin
         mismatched++;
         $display("[TB] FAIL abort_ct: got v=%h expected all zero", ct_v);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sawDone = 0;
      repeat (14) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) sawDone++;
      end
      compared++;
      if (sawDone != 0) begin mismatched++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", sawDone); end
      applyStimulus(ONES, '0, '0, CT_ONES);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(20, cyc, seen);
      compared++;
      if (!seen || cyc + 1 != 12) begin
         mismatched++;
         $display("[TB] FAIL rerun_latency: got %0d (seen=%0b) expected 12", cyc + 1, seen);
      end
      popExpected(e);
      compared++;
      if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL rerun_ct: got %h expected %h", ctXor(), e); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc; bit seen; int sawDone; logic [63:0] e;
      logic [63:0] pts  [3] = '{64'h0, ONES, PT_MIXED};
      logic [63:0] k0s  [3] = '{64'h0, 64'h0, 64'h0};
      logic [63:0] k1s  [3] = '{64'h0, 64'h0, K1_MIXED};
      logic [63:0] exps [3] = '{CT_ZERO, CT_ONES, CT_MIXED};
      applyStimulus(pts[0], k0s[0], k1s[0], exps[0]);
      start = 1'b1;
      for (int n = 0; n < 3; n++) begin
         waitDone(20, cyc, seen);
         compared++;
         if (!seen || cyc != (n == 0 ? 12 : 13)) begin
            mismatched++;
            $display("[TB] FAIL b2b_period%0d: got %0d (seen=%0b) expected %0d", n, cyc, seen, (n == 0 ? 12 : 13));
         end
         popExpected(e);
         compared++;
         if (ctXor() !== e) begin mismatched++; $display("[TB] FAIL b2b_ct%0d: got %h expected %h", n, ctXor(), e); end
         if (n < 2) applyStimulus(pts[n+1], k0s[n+1], k1s[n+1], exps[n+1]);
         else start = 1'b0;
      end
      sawDone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done !== 1'b0) sawDone++;
      end
      compared++;
      if (sawDone != 0) begin mismatched++; $display("[TB] FAIL b2b_extra_done: got %0d pulses expected 0", sawDone); end
   endtask

   initial begin
      test_reset();
      test_zero_vector();
      test_ones_vector();
      test_key_vectors();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
